// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: issues a one-cycle grant, tracks begin/end of the
// owner's transaction and uses a watchdog to recover from stalled masters or slaves.
module bus_arbiter_rr #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         request,
    output logic [NUM_REQ-1:0]         grant,
    input  logic                       beginTransactionIn,
    input  logic                       endTransactionIn,
    input  logic                       busErrorIn,
    output logic [$clog2(NUM_REQ)-1:0] busOwner,
    output logic                       busBusy,
    output logic                       endTransactionOut,
    output logic                       timeoutOut
);
    localparam int unsigned OWNER_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W    = 16;
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [OWNER_W-1:0] PTR_RESET = OWNER_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_BEGIN,
        BUSY,
        FORCE_END
    } arbState;

    arbState            state;
    logic [OWNER_W-1:0] ptr;
    logic [WD_W-1:0]    watchdog;
    logic [WD_W-1:0]    watchdogNext;
    logic [OWNER_W-1:0] winner;
    logic               found;
    logic               wdExpired;
    logic               transferDone;

    // First set request bit searching upward from ptr+1, wrapping at NUM_REQ.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!found && (|(request & (NUM_REQ'(1) << ((32'(ptr) + i) % NUM_REQ))))) begin
                winner = OWNER_W'((32'(ptr) + i) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    // The watchdog saturates so a very long stall can never wrap back to zero.
    assign watchdogNext = (watchdog == '1) ? watchdog : watchdog + WD_W'(1);
    assign wdExpired    = (watchdog == WD_LAST);
    assign transferDone = endTransactionIn | busErrorIn;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            grant             <= '0;
            busOwner          <= '0;
            busBusy           <= 1'b0;
            endTransactionOut <= 1'b0;
            timeoutOut        <= 1'b0;
            watchdog          <= '0;
            ptr               <= PTR_RESET;
        end else begin
            grant             <= '0;
            endTransactionOut <= 1'b0;
            timeoutOut        <= 1'b0;
            case (state)
                IDLE: begin
                    busBusy <= 1'b0;
                    if (found) begin
                        state    <= GRANT;
                        busOwner <= winner;
                        ptr      <= winner;
                        grant    <= NUM_REQ'(1) << winner;
                        busBusy  <= 1'b1;
                    end
                end
                GRANT: begin
                    state    <= WAIT_BEGIN;
                    watchdog <= '0;
                end
                WAIT_BEGIN: begin
                    watchdog <= watchdogNext;
                    if (beginTransactionIn) begin
                        state    <= BUSY;
                        watchdog <= '0;
                    end else if (transferDone) begin
                        state   <= IDLE;
                        busBusy <= 1'b0;
                    end else if (wdExpired) begin
                        // Master never started: nothing on the bus to terminate.
                        state      <= IDLE;
                        busBusy    <= 1'b0;
                        timeoutOut <= 1'b1;
                    end
                end
                BUSY: begin
                    watchdog <= watchdogNext;
                    if (transferDone) begin
                        state   <= IDLE;
                        busBusy <= 1'b0;
                    end else if (wdExpired) begin
                        state             <= FORCE_END;
                        endTransactionOut <= 1'b1;
                        timeoutOut        <= 1'b1;
                    end
                end
                FORCE_END: begin
                    state   <= IDLE;
                    busBusy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busBusy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: a transaction-level model predicts grant
// cycles/owners, watchdog pulses and busy windows; a monitor compares them.
module tb_bus_arbiter_rr;
    localparam int NREQ = 4;
    localparam int TMO = 8;
    localparam int BUSY_DEPTH = 8192;

    localparam int K_NORMAL = 0;
    localparam int K_ENDNB  = 1;
    localparam int K_TMO    = 2;
    localparam int K_HUNG   = 3;
    localparam int K_RST    = 4;

    typedef struct {
        int cyc;
        int owner;
    } grantExp_t;

    typedef struct {
        int cyc;
        bit forced;
    } tmoExp_t;

    typedef struct {
        int             kind;
        logic [NREQ-1:0] mask;
        int             d;
        int             e;
        int             gap;
        bit             useErr;
        bit             ovl;
    } ep_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NREQ-1:0] request = '0;
    logic [NREQ-1:0] grant;
    logic            beginTransactionIn = 1'b0;
    logic            endTransactionIn = 1'b0;
    logic            busErrorIn = 1'b0;
    logic [1:0]      busOwner;
    logic            busBusy;
    logic            endTransactionOut;
    logic            timeoutOut;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int ptrM = NREQ - 1;
    int idleM = 0;
    int lastGrant = -1;
    bit expBusy [0:BUSY_DEPTH-1];
    grantExp_t grantQ[$];
    tmoExp_t   tmoQ[$];
    ep_t       eps[$];

    bus_arbiter_rr #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .clock(clock),
        .reset(reset),
        .request(request),
        .grant(grant),
        .beginTransactionIn(beginTransactionIn),
        .endTransactionIn(endTransactionIn),
        .busErrorIn(busErrorIn),
        .busOwner(busOwner),
        .busBusy(busBusy),
        .endTransactionOut(endTransactionOut),
        .timeoutOut(timeoutOut)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL globalTimeout cyc=%0d required finish earlier", cyc);
        $fatal(1, "bench timeout");
    end

    // Round-robin rule: first requester at or after ptr+1, wrapping.
    function automatic int pickWinner(input logic [NREQ-1:0] m, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic addEp(input int kind, input logic [NREQ-1:0] mask, input int d, input int e,
                         input bit useErr, input bit ovl, input int gap);
        ep_t ep;
        ep.kind = kind; ep.mask = mask; ep.d = d; ep.e = e;
        ep.useErr = useErr; ep.gap = gap;
        ep.ovl = ovl && (eps.size() > 0) && (eps[eps.size()-1].kind != K_RST) && (kind != K_RST);
        eps.push_back(ep);
    endtask

    task automatic waitCyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic markBusy(input int a, input int b);
        for (int k = a; k <= b; k++) if (k < BUSY_DEPTH) expBusy[k] = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checks++;
        if (grant !== '0 || busOwner !== '0 || busBusy !== 1'b0 ||
            endTransactionOut !== 1'b0 || timeoutOut !== 1'b0) begin
            errors++;
            $display("FAIL %s got grant=%b owner=%0d busy=%b endOut=%b tmo=%b required all zero",
                     tag, grant, busOwner, busBusy, endTransactionOut, timeoutOut);
        end
    endtask

    task automatic runEp(input int i);
        ep_t ep;
        int c, g, w, idleNew;
        logic [NREQ-1:0] fin;
        ep = eps[i];
        fin = (i + 1 < eps.size() && eps[i+1].ovl) ? eps[i+1].mask : '0;
        if (!ep.ovl) begin
            waitCyc(idleM + ep.gap);
            request = ep.mask;
        end
        c = cyc;
        g = ((c > idleM) ? c : idleM) + 1;
        w = pickWinner(ep.mask, ptrM);
        ptrM = w;
        grantQ.push_back('{g, w});
        case (ep.kind)
            K_NORMAL: idleNew = g + ep.d + ep.e + 1;
            K_ENDNB:  idleNew = g + ep.d + 1;
            K_TMO:    idleNew = g + 1 + TMO;
            K_HUNG:   idleNew = g + ep.d + 2 + TMO;
            default:  idleNew = g + 5;
        endcase
        if (ep.kind == K_TMO) tmoQ.push_back('{g + 1 + TMO, 1'b0});
        if (ep.kind == K_HUNG) tmoQ.push_back('{g + ep.d + 1 + TMO, 1'b1});
        markBusy(g, idleNew - 1);
        waitCyc(g);
        // Requests seen during ownership must not matter, including the winner dropping out.
        request = (ep.kind == K_RST) ? '0 : NREQ'($urandom);
        case (ep.kind)
            K_NORMAL: begin
                waitCyc(g + ep.d);     beginTransactionIn = 1'b1;
                waitCyc(g + ep.d + 1); beginTransactionIn = 1'b0;
                waitCyc(g + ep.d + ep.e);
                if (ep.useErr) busErrorIn = 1'b1; else endTransactionIn = 1'b1;
                request = fin;
                waitCyc(idleNew);
                busErrorIn = 1'b0; endTransactionIn = 1'b0;
            end
            K_ENDNB: begin
                waitCyc(g + ep.d);
                if (ep.useErr) busErrorIn = 1'b1; else endTransactionIn = 1'b1;
                request = fin;
                waitCyc(idleNew);
                busErrorIn = 1'b0; endTransactionIn = 1'b0;
            end
            K_TMO: begin
                waitCyc(idleNew - 1);
                request = fin;
            end
            K_HUNG: begin
                waitCyc(g + ep.d);     beginTransactionIn = 1'b1;
                waitCyc(g + ep.d + 1); beginTransactionIn = 1'b0;
                waitCyc(idleNew - 1);
                request = fin;
            end
            default: begin
                waitCyc(g + 1); beginTransactionIn = 1'b1;
                waitCyc(g + 2); beginTransactionIn = 1'b0;
                waitCyc(g + 4);
                #2 reset = 1'b0;
                #1 checkResetOutputs("asyncResetInBusy");
                @(negedge clock);
                @(negedge clock);
                reset = 1'b1;
                ptrM = NREQ - 1;
                idleNew = cyc;
            end
        endcase
        idleM = idleNew;
    endtask

    // Monitor: compares DUT outputs against the queued predictions each cycle.
    always @(negedge clock) begin
        grantExp_t ge;
        tmoExp_t   te;
        if (cyc < BUSY_DEPTH) begin
            checks++;
            if (busBusy !== expBusy[cyc]) begin
                errors++;
                $display("FAIL busBusy cyc=%0d got %b required %b", cyc, busBusy, expBusy[cyc]);
            end
        end
        while (grantQ.size() > 0 && grantQ[0].cyc < cyc) begin
            ge = grantQ.pop_front();
            checks++; errors++;
            $display("FAIL grantMissing cyc=%0d got none required owner %0d", ge.cyc, ge.owner);
        end
        while (tmoQ.size() > 0 && tmoQ[0].cyc < cyc) begin
            te = tmoQ.pop_front();
            checks++; errors++;
            $display("FAIL timeoutMissing cyc=%0d got none required forced=%b", te.cyc, te.forced);
        end
        if (grant !== '0) begin
            checks++;
            if (grantQ.size() == 0) begin
                errors++;
                $display("FAIL grantUnexpected cyc=%0d got %b required none", cyc, grant);
            end else begin
                ge = grantQ.pop_front();
                if (grant !== (NREQ'(1) << ge.owner) || busOwner !== 2'(ge.owner) || cyc != ge.cyc) begin
                    errors++;
                    $display("FAIL grant cyc=%0d got grant=%b owner=%0d required cyc=%0d grant=%b owner=%0d",
                             cyc, grant, busOwner, ge.cyc, NREQ'(1) << ge.owner, ge.owner);
                end
            end
            if (lastGrant >= 0) begin
                checks++;
                if (cyc - lastGrant < 4) begin
                    errors++;
                    $display("FAIL grantSpacing cyc=%0d got %0d required >=4", cyc, cyc - lastGrant);
                end
            end
            lastGrant = cyc;
        end
        if (timeoutOut !== 1'b0 || endTransactionOut !== 1'b0) begin
            checks++;
            if (tmoQ.size() == 0) begin
                errors++;
                $display("FAIL timeoutUnexpected cyc=%0d got tmo=%b endOut=%b required none",
                         cyc, timeoutOut, endTransactionOut);
            end else begin
                te = tmoQ.pop_front();
                if (timeoutOut !== 1'b1 || endTransactionOut !== te.forced || cyc != te.cyc) begin
                    errors++;
                    $display("FAIL timeout cyc=%0d got tmo=%b endOut=%b required cyc=%0d tmo=1 endOut=%b",
                             cyc, timeoutOut, endTransactionOut, te.cyc, te.forced);
                end
            end
        end
    end

    initial begin
        int r;
        // Directed: contention order, wrap/skip, single master, watchdogs, errors, reset.
        addEp(K_NORMAL, 4'b1111, 1, 1, 0, 0, 0);
        addEp(K_NORMAL, 4'b1111, 1, 1, 0, 1, 0);
        addEp(K_NORMAL, 4'b1111, 1, 1, 0, 1, 0);
        addEp(K_NORMAL, 4'b1111, 1, 1, 0, 1, 0);
        addEp(K_NORMAL, 4'b1111, 2, 2, 0, 1, 0);
        addEp(K_NORMAL, 4'b1000, 1, 2, 0, 0, 1);
        addEp(K_NORMAL, 4'b1010, 1, 2, 0, 0, 0);
        addEp(K_NORMAL, 4'b1010, 1, 2, 0, 1, 0);
        addEp(K_NORMAL, 4'b0001, 2, 5, 0, 0, 1);
        addEp(K_TMO,    4'b0110, 1, 1, 0, 0, 0);
        addEp(K_NORMAL, 4'b0110, 1, 1, 0, 1, 0);
        addEp(K_HUNG,   4'b0001, 2, 1, 0, 0, 1);
        addEp(K_NORMAL, 4'b0001, 1, 3, 1, 0, 0);
        addEp(K_ENDNB,  4'b1000, 2, 1, 1, 0, 0);
        addEp(K_RST,    4'b0100, 1, 1, 0, 0, 0);
        addEp(K_NORMAL, 4'b1111, 1, 2, 0, 0, 0);
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            addEp((r < 50) ? K_NORMAL : (r < 65) ? K_ENDNB : (r < 78) ? K_TMO : (r < 94) ? K_HUNG : K_RST,
                  NREQ'($urandom_range(1, 15)), (r >= 50 && r < 65) ? $urandom_range(2, 4) : $urandom_range(1, 4),
                  $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2));
        end

        @(negedge clock);
        checkResetOutputs("initialReset");
        reset = 1'b1;
        idleM = cyc;

        for (int i = 0; i < eps.size(); i++) runEp(i);

        waitCyc(cyc + 20);
        checks++;
        if (grantQ.size() != 0 || tmoQ.size() != 0) begin
            errors++;
            $display("FAIL pendingAtEnd got grants=%0d timeouts=%0d required 0", grantQ.size(), tmoQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
